// File: rtl/wb_stage.sv
// MEM/WB pipeline register and write-back formatter feeding the GRF write port.
// Optional simulation trace of committed writes is enabled by defining WB_TRACE_EN.
module wb_stage #(
    parameter int          RETIRE_W    = 32,
    parameter logic [31:0] LINK_OFFSET = 32'd8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stall,
    input  logic                flush,
    input  logic                mem_valid,
    input  logic [31:0]         mem_pc,
    input  logic [31:0]         mem_alu_result,
    input  logic [31:0]         mem_read_data,
    input  logic [4:0]          mem_rd,
    input  logic                mem_reg_write,
    input  logic [1:0]          mem_wb_sel,
    input  logic [2:0]          mem_load_type,
    output logic                writeEnable,
    output logic [4:0]          writeReg,
    output logic [31:0]         writeData,
    output logic [31:0]         PCReg,
    output logic                fwd_valid,
    output logic [4:0]          fwd_reg,
    output logic [31:0]         fwd_data,
    output logic [RETIRE_W-1:0] retire_count
);

    localparam logic [2:0] LT_LB  = 3'b001;
    localparam logic [2:0] LT_LBU = 3'b010;
    localparam logic [2:0] LT_LH  = 3'b011;
    localparam logic [2:0] LT_LHU = 3'b100;

    localparam logic [1:0] SEL_LOAD = 2'b01;
    localparam logic [1:0] SEL_LINK = 2'b10;

    localparam logic [RETIRE_W-1:0] RETIRE_ONE = {{(RETIRE_W-1){1'b0}}, 1'b1};

    // Load data extension: pick byte/halfword by address offset, then sign/zero extend.
    function automatic logic [31:0] f_load_ext(
        input logic [2:0]  load_type,
        input logic [1:0]  offset,
        input logic [31:0] word
    );
        logic [7:0]  v_byte;
        logic [15:0] v_half;
        logic [31:0] v_out;
        case (offset)
            2'd0:    v_byte = word[7:0];
            2'd1:    v_byte = word[15:8];
            2'd2:    v_byte = word[23:16];
            2'd3:    v_byte = word[31:24];
            default: v_byte = word[7:0];
        endcase
        if (offset[1]) begin
            v_half = word[31:16];
        end else begin
            v_half = word[15:0];
        end
        case (load_type)
            LT_LB:   v_out = {{24{v_byte[7]}}, v_byte};
            LT_LBU:  v_out = {24'd0, v_byte};
            LT_LH:   v_out = {{16{v_half[15]}}, v_half};
            LT_LHU:  v_out = {16'd0, v_half};
            default: v_out = word;
        endcase
        return v_out;
    endfunction

    // Write-back source mux; 2'b11 aliases the ALU path.
    function automatic logic [31:0] f_wb_select(
        input logic [1:0]  wb_sel,
        input logic [31:0] alu,
        input logic [31:0] load_val,
        input logic [31:0] pc
    );
        logic [31:0] v_out;
        case (wb_sel)
            SEL_LOAD: v_out = load_val;
            SEL_LINK: v_out = pc + LINK_OFFSET;
            default:  v_out = alu;
        endcase
        return v_out;
    endfunction

    logic [31:0] w_load_data;
    logic [31:0] w_wb_data;
    logic        w_write_en;

    logic                r_valid;
    logic                r_we;
    logic [4:0]          r_reg;
    logic [31:0]         r_data;
    logic [31:0]         r_pc;
    logic                r_fwd_valid;
    logic [4:0]          r_fwd_reg;
    logic [31:0]         r_fwd_data;
    logic [RETIRE_W-1:0] r_retire;

    // Format the incoming memory-stage result before it is registered.
    always_comb begin
        w_load_data = f_load_ext(mem_load_type, mem_alu_result[1:0], mem_read_data);
        w_wb_data   = f_wb_select(mem_wb_sel, mem_alu_result, w_load_data, mem_pc);
        if (mem_valid && mem_reg_write && (mem_rd != 5'd0)) begin
            w_write_en = 1'b1;
        end else begin
            w_write_en = 1'b0;
        end
    end

    // Stage register: flush beats stall; an invalid incoming slot becomes a bubble.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid     <= 1'b0;
            r_we        <= 1'b0;
            r_reg       <= 5'd0;
            r_data      <= 32'd0;
            r_pc        <= 32'd0;
            r_fwd_valid <= 1'b0;
            r_fwd_reg   <= 5'd0;
            r_fwd_data  <= 32'd0;
        end else if (flush || (!stall && !mem_valid)) begin
            r_valid     <= 1'b0;
            r_we        <= 1'b0;
            r_reg       <= 5'd0;
            r_data      <= 32'd0;
            r_pc        <= 32'd0;
            r_fwd_valid <= 1'b0;
            r_fwd_reg   <= 5'd0;
            r_fwd_data  <= 32'd0;
        end else if (!stall) begin
            r_valid     <= 1'b1;
            r_we        <= w_write_en;
            r_reg       <= mem_rd;
            r_data      <= w_wb_data;
            r_pc        <= mem_pc;
            r_fwd_valid <= w_write_en;
            r_fwd_reg   <= w_write_en ? mem_rd : 5'd0;
            r_fwd_data  <= w_write_en ? w_wb_data : 32'd0;
        end else begin
            r_valid     <= r_valid;
            r_we        <= r_we;
            r_reg       <= r_reg;
            r_data      <= r_data;
            r_pc        <= r_pc;
            r_fwd_valid <= r_fwd_valid;
            r_fwd_reg   <= r_fwd_reg;
            r_fwd_data  <= r_fwd_data;
        end
    end

    // Count each instruction once, on the edge that accepts it into the stage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_retire <= {RETIRE_W{1'b0}};
        end else if (!flush && !stall && mem_valid) begin
            r_retire <= r_retire + RETIRE_ONE;
        end else begin
            r_retire <= r_retire;
        end
    end

`ifdef WB_TRACE_EN
`ifndef SYNTHESIS
    // Trace each committed GRF write once; held stall cycles are rewrites and are skipped.
    always @(posedge clk) begin
        if (reset && r_we && !stall) begin
            $display("@%08h: $%02d <= %08h", r_pc, r_reg, r_data);
        end
    end
`endif
`endif

    assign writeEnable  = r_we;
    assign writeReg     = r_reg;
    assign writeData    = r_data;
    assign PCReg        = r_pc;
    assign fwd_valid    = r_fwd_valid;
    assign fwd_reg      = r_fwd_reg;
    assign fwd_data     = r_fwd_data;
    assign retire_count = r_retire;

    logic w_unused;
    assign w_unused = r_valid;

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
MEM/WB pipeline register and write-back formatter that sits directly upstream of the general register file (grf).
- Captures the memory-stage result and extends load data by byte/halfword.
- Selects the write-back source and drives the grf write port (writeEnable, writeReg, writeData, PCReg).
- Provides a forwarding copy of the pending write to the hazard unit and counts retired instructions.

Parameters:
RETIRE_W, 32, width of the retired-instruction counter
LINK_OFFSET, 8, byte offset added to the PC for link write-back (jal/jalr)

Ports:
clk  input  1  clock, rising-edge active
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
stall  input  1  hold the current stage contents
flush  input  1  load a bubble instead of the incoming instruction
mem_valid  input  1  memory stage holds a real instruction
mem_pc  input  32  PC of the memory-stage instruction
mem_alu_result  input  32  ALU result or load address
mem_read_data  input  32  raw aligned word from data memory
mem_rd  input  5  destination register
mem_reg_write  input  1  instruction writes the GRF
mem_wb_sel  input  2  00 ALU, 01 load, 10 link, 11 ALU
mem_load_type  input  3  000 lw, 001 lb, 010 lbu, 011 lh, 100 lhu, others treated as lw
writeEnable  output  1  GRF write enable
writeReg  output  5  GRF write address
writeData  output  32  GRF write data
PCReg  output  32  PC of the writing instruction (for GRF trace)
fwd_valid  output  1  a forwardable write is pending
fwd_reg  output  5  forwarding register number
fwd_data  output  32  forwarding data
retire_count  output  RETIRE_W  number of valid instructions retired

Behaviour:
- Reset (reset=0, asynchronous): all internal registers and all outputs are 0; retire_count=0. On release, the first capture happens at the next rising clk.
- Capture rule per rising edge, highest priority first:
  - flush=1: load a bubble (valid=0, reg_write=0, rd=0, data=0, pc=0). Flush wins over stall.
  - stall=1: hold all registers.
  - otherwise: capture formatted data from the memory stage.
- Latency: exactly 1 cycle from MEM inputs to GRF outputs. All outputs are driven from registers, with no combinational path from inputs.
- Data formatting is computed before the register; byte offset b = mem_alu_result[1:0]:
  - lb: byte b, sign-extended. lbu: byte b, zero-extended. Byte 0 = bits [7:0].
  - lh: halfword mem_alu_result[1] (0 → [15:0], 1 → [31:16]), sign-extended; lhu zero-extends. mem_alu_result[0] is ignored.
  - lw and load types 101–111: full word.
  - wb_sel=10: mem_pc + LINK_OFFSET, modulo 2^32 (wraps, no overflow flag).
  - wb_sel=00 or 11: mem_alu_result.
- writeEnable = valid & reg_write & (rd != 0). Register 0 is never written.
- writeReg = rd and PCReg = pc whenever valid=1, even when writeEnable=0. They are 0 for bubbles.
- Forwarding: fwd_valid = writeEnable, fwd_reg = writeReg, fwd_data = writeData. All three are 0 whenever fwd_valid=0.
- retire_count increments by 1 on each edge where the stage holds valid=1 and the edge is not a stall hold. A flushed slot or a held instruction is not counted twice. The counter wraps at 2^RETIRE_W − 1 → 0.
- Stall while holding a write: writeEnable stays asserted for each held cycle. The GRF rewrites the same value, which is harmless.
- Reset mid-operation immediately clears the pending write. No partial write occurs.

Optional Feature:
WB_TRACE_EN
- Defined: on each rising edge with writeEnable=1 and stall=0, the block prints "@<PCReg 8 hex>: $<writeReg 2 dec> <= <writeData 8 hex>" using $display.
  - Simulation only, and guarded so it never synthesises.
- Undefined: no display statements are present and behaviour is identical otherwise.

Test Plan:
- Reset held low 3 cycles, inputs random → all outputs 0, retire_count=0; release, then a bubble cycle → outputs remain 0.
- ALU op: pc=0x00003000, alu=0x12345678, rd=10, wb_sel=00 → next cycle writeEnable=1, writeReg=10, writeData=0x12345678, PCReg=0x00003000, retire_count=1.
- Loads with read_data=0x80FF7F01:
  - lb b=3 → 0xFFFFFF80; lbu b=1 → 0x0000007F.
  - lh alu[1]=1 → 0xFFFF80FF; lhu alu[1]=0 → 0x00007F01.
  - load_type=111 → 0x80FF7F01.
- Link and r0: wb_sel=10, pc=0xFFFFFFFC → writeData=0x00000004. Same with rd=0 → writeEnable=0, fwd_valid=0, PCReg=0xFFFFFFFC.
- Stall/flush:
  - Capture a write to $5, then stall 2 cycles → outputs held, retire_count unchanged.
  - stall=1 and flush=1 together → bubble, writeEnable=0.
- Async reset asserted mid-cycle while writeEnable=1 → writeEnable drops to 0 before the next edge; with WB_TRACE_EN defined, exactly one trace line is printed per committed write.
